// File: rtl/fc_sequencer.sv
// fc_sequencer: feeds one fc_layer image, steps it through every class, and reports the signed argmax
module fc_sequencer #(
    parameter int NUM_INPUT_DATA  = 48,
    parameter int NUM_OUTPUT_DATA = 10,
    parameter int DATA_W          = 12,
    parameter int CLASS_W         = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATA_W-1:0]  in_data_1,
    input  logic signed [DATA_W-1:0]  in_data_2,
    input  logic signed [DATA_W-1:0]  in_data_3,
    output logic                      dp_rst,
    output logic                      dp_valid_in,
    output logic signed [DATA_W-1:0]  dp_data_1,
    output logic signed [DATA_W-1:0]  dp_data_2,
    output logic signed [DATA_W-1:0]  dp_data_3,
    input  logic                      dp_valid_out,
    input  logic signed [DATA_W-1:0]  dp_out_data,
    output logic                      result_valid,
    input  logic                      result_ready,
    output logic [CLASS_W-1:0]        result_class,
    output logic signed [DATA_W-1:0]  result_score
);
    localparam int BEATS = NUM_INPUT_DATA / 3;
    localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
    typedef enum logic [2:0] {LOAD, WAIT, STEP, DONE, FLUSH} state_t;
    state_t state, state_n;
    logic [BW-1:0] beat_cnt;
    logic [CLASS_W-1:0] cls_cnt, best_class;
    logic signed [DATA_W-1:0] best_score;
    logic beat, last_beat, cap, last_cls;
    assign beat      = state == LOAD && in_valid;
    assign last_beat = beat && beat_cnt == BW'(BEATS - 1);
    assign cap       = state == WAIT && dp_valid_out;
    assign last_cls  = cls_cnt == CLASS_W'(NUM_OUTPUT_DATA - 1);
    assign in_ready     = !rst && state == LOAD;
    assign dp_valid_in  = !rst && (beat || state == STEP);
    assign dp_rst       = rst || state == FLUSH;
    assign dp_data_1    = in_data_1;
    assign dp_data_2    = in_data_2;
    assign dp_data_3    = in_data_3;
    assign result_valid = !rst && state == DONE;
    assign result_class = rst ? '0 : best_class;
    assign result_score = rst ? '0 : best_score;
    always_comb begin
        state_n = state;
        case (state)
            LOAD:    state_n = last_beat ? WAIT : LOAD;
            WAIT:    state_n = cap ? (last_cls ? DONE : STEP) : WAIT;
            STEP:    state_n = WAIT;
            DONE:    state_n = result_ready ? FLUSH : DONE;
            FLUSH:   state_n = LOAD;
            default: state_n = LOAD;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD;
            beat_cnt   <= '0;
            cls_cnt    <= '0;
            best_class <= '0;
            best_score <= '0;
        end else begin
            state <= state_n;
            if (beat)
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            if (cap) begin
                cls_cnt <= last_cls ? cls_cnt : cls_cnt + 1'b1;
                // strict compare keeps the lowest index on ties
                if (cls_cnt == '0 || dp_out_data > best_score) begin
                    best_score <= dp_out_data;
                    best_class <= cls_cnt;
                end
            end
            if (state == FLUSH)
                cls_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_fc_sequencer.sv
// tb_fc_sequencer: directed image vectors against a behavioural fc_layer datapath model
module tb_fc_sequencer;
    logic clk = 0, rst = 1;
    logic in_valid = 0, in_ready;
    logic signed [11:0] in_data_1 = 0, in_data_2 = 0, in_data_3 = 0;
    logic dp_rst, dp_valid_in;
    logic signed [11:0] dp_data_1, dp_data_2, dp_data_3;
    logic dp_valid_out = 0;
    logic signed [11:0] dp_out_data = 0;
    logic result_valid, result_ready = 0;
    logic [3:0] result_class;
    logic signed [11:0] result_score;
    logic signed [11:0] sc [10];
    int total = 0, bad = 0;
    int loads = 0, steps = 0, idx = 0;

    always #5 clk = ~clk;

    fc_sequencer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data_1(in_data_1), .in_data_2(in_data_2), .in_data_3(in_data_3),
        .dp_rst(dp_rst), .dp_valid_in(dp_valid_in),
        .dp_data_1(dp_data_1), .dp_data_2(dp_data_2), .dp_data_3(dp_data_3),
        .dp_valid_out(dp_valid_out), .dp_out_data(dp_out_data),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_class(result_class), .result_score(result_score)
    );

    // datapath: score 0 one cycle after the 16th load beat, then one score per step pulse
    always @(posedge clk) begin
        dp_valid_out <= 0;
        if (dp_rst) begin
            loads <= 0;
            steps <= 0;
            idx   <= 0;
        end else if (dp_valid_in) begin
            if (loads < 16) begin
                loads <= loads + 1;
                if (loads == 15) begin
                    dp_valid_out <= 1;
                    dp_out_data  <= sc[0];
                    idx          <= 1;
                end
            end else begin
                steps <= steps + 1;
                if (idx < 10) begin
                    dp_valid_out <= 1;
                    dp_out_data  <= sc[idx];
                    idx          <= idx + 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input bit tog);
        int n = 0, g = 0;
        while (n < 16 && g < 100) begin
            @(negedge clk);
            in_valid  = tog ? (g % 2 == 0) : 1'b1;
            in_data_1 = 12'(n * 3);
            in_data_2 = 12'(-n);
            in_data_3 = 12'(7);
            #1;
            if (g == 1) chk("fwd", int'(dp_data_2), int'(in_data_2));
            if (in_valid && in_ready) n++;
            g++;
            @(posedge clk);
        end
        chk("beats", n, 16);
    endtask

    task automatic image(input string nm, input bit tog, input bit hold, input int ecls, input int escore);
        int t = 0;
        bit ok = 1;
        send(tog);
        do begin
            @(negedge clk);
            t++;
            if (t == 1) chk({nm, "_wait_entry"}, int'(in_ready), 0);
        end while (!result_valid && t < 100);
        chk({nm, "_latency"}, t, 20);
        chk({nm, "_class"}, int'(result_class), ecls);
        chk({nm, "_score"}, int'(result_score), escore);
        chk({nm, "_loads"}, loads, 16);
        chk({nm, "_steps"}, steps, 9);
        if (hold) begin
            repeat (20) begin
                @(negedge clk);
                if (!result_valid || result_class != 4'(ecls) || result_score != 12'(escore) ||
                    in_ready || dp_valid_in) ok = 0;
            end
            chk({nm, "_hold"}, int'(ok), 1);
        end
        in_valid     = 0;
        result_ready = 1;
        @(negedge clk);
        chk({nm, "_flush_rst"}, int'(dp_rst), 1);
        chk({nm, "_flush_valid"}, int'(result_valid), 0);
        chk({nm, "_flush_ready"}, int'(in_ready), 0);
        result_ready = 0;
        @(negedge clk);
        chk({nm, "_rearm_rst"}, int'(dp_rst), 0);
        chk({nm, "_rearm_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        int s = 0, t = 0;
        for (int i = 0; i < 10; i++) sc[i] = 0;
        in_valid = 1;
        repeat (3) @(negedge clk);
        chk("rst_valid", int'(result_valid), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_dp_rst", int'(dp_rst), 1);
        chk("rst_dp_valid", int'(dp_valid_in), 0);
        chk("rst_class", int'(result_class), 0);
        chk("rst_score", int'(result_score), 0);
        in_valid = 0;
        rst = 0;
        #1 chk("rst_release_ready", int'(in_ready), 1);

        sc = '{12'sd5, -12'sd3, 12'sd0, 12'sd12, 12'sd7, 12'sd1, 12'sd2, 12'sd40, -12'sd8, 12'sd39};
        image("t1", 0, 1, 7, 40);

        for (int i = 0; i < 10; i++) sc[i] = 12'sd100;
        image("t2", 0, 0, 0, 100);

        for (int i = 0; i < 10; i++) sc[i] = 12'(-20 + i);
        result_ready = 1;
        image("t3", 0, 0, 9, -11);

        sc = '{12'sd5, -12'sd3, 12'sd0, 12'sd12, 12'sd7, 12'sd1, 12'sd2, 12'sd40, -12'sd8, 12'sd39};
        image("t4", 1, 0, 7, 40);

        sc = '{12'sd1, 12'sd2, 12'sd3, 12'sd4, 12'sd50, 12'sd6, 12'sd50, 12'sd8, 12'sd9, 12'sd10};
        send(0);
        while (s < 4 && t < 100) begin
            @(negedge clk);
            if (dp_valid_out) s++;
            t++;
        end
        chk("t6_captures", s, 4);
        repeat (2) @(negedge clk);
        in_valid = 0;
        rst = 1;
        #1;
        chk("t6_rst_dp_rst", int'(dp_rst), 1);
        chk("t6_rst_in_ready", int'(in_ready), 0);
        chk("t6_rst_dp_valid", int'(dp_valid_in), 0);
        @(negedge clk);
        chk("t6_rst_result", int'(result_valid), 0);
        rst = 0;
        #1 chk("t6_back_to_load", int'(in_ready), 1);
        image("t6", 0, 0, 4, 50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
